// File: rtl/rom_stream_reader.sv
// Burst sequencer for a 16x4 registered ROM: issues reads, captures data one cycle
// later into a 2-entry buffer, and streams words out on valid/ready with an XOR checksum.
module rom_stream_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] start_addr,
  input  logic [3:0] len_m1,
  output logic       rom_enable,
  output logic [3:0] rom_address,
  input  logic [3:0] rom_data,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] checksum,
  output logic [1:0] dbg_state
);

  // Stream handshake: a word transfers in any cycle where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer happens.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [4:0] issue_left_q, issue_left_d;
  logic [4:0] deliver_left_q, deliver_left_d;
  logic       inflight_q, inflight_d;
  logic [3:0] buf0_q, buf0_d;
  logic [3:0] buf1_q, buf1_d;
  logic [1:0] count_q, count_d;
  logic [3:0] checksum_q, checksum_d;

  logic       pop;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] count_tmp;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    checksum_d     = checksum_q;
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    count_tmp      = count_q;

    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
    out_valid = (count_q != 2'd0);
    out_data  = buf0_q;
    pop       = out_valid && out_ready;

    // A read in flight counts against the buffer so a full buffer can never overflow.
    occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
    issue       = (state_q == S_RUN) && (issue_left_q != 5'd0) &&
                  ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));
    rom_enable  = issue;
    rom_address = issue ? addr_q : 4'd0;
    inflight_d  = issue;

    case (state_q)
      S_RUN: begin
        if (issue) begin
          addr_d       = addr_q + 4'd1;
          issue_left_d = issue_left_q - 5'd1;
        end
        if (pop) begin
          checksum_d     = checksum_q ^ buf0_q;
          deliver_left_d = deliver_left_q - 5'd1;
          if (deliver_left_q == 5'd1) state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          state_d        = S_RUN;
          addr_d         = start_addr;
          issue_left_d   = {1'b0, len_m1} + 5'd1;
          deliver_left_d = {1'b0, len_m1} + 5'd1;
          checksum_d     = 4'd0;
        end
      end
    endcase

    // Pop shifts the head out first, then the captured word lands at the new tail.
    if (pop) begin
      buf0_d    = buf1_q;
      count_tmp = count_q - 2'd1;
    end
    if (inflight_q) begin
      if (count_tmp == 2'd0) buf0_d = rom_data;
      else                   buf1_d = rom_data;
      count_tmp = count_tmp + 2'd1;
    end
    count_d = count_tmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= 4'd0;
      issue_left_q   <= 5'd0;
      deliver_left_q <= 5'd0;
      inflight_q     <= 1'b0;
      buf0_q         <= 4'd0;
      buf1_q         <= 4'd0;
      count_q        <= 2'd0;
      checksum_q     <= 4'd0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      inflight_q     <= inflight_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      count_q        <= count_d;
      checksum_q     <= checksum_d;
    end
  end

  assign checksum = checksum_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM model, directed bursts, queue-based stream scoreboard.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [3:0] len_m1;
  logic       rom_enable;
  logic [3:0] rom_address;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [3:0] checksum;
  logic [1:0] dbg_state;

  rom_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len_m1(len_m1),
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ROM image: word[i] = 15-i, except word[13] = A. Registered, X when not enabled.
  always @(posedge clk) begin
    if (rom_enable) rom_data <= (rom_address == 4'd13) ? 4'hA : (4'hF - rom_address);
    else            rom_data <= 4'bxxxx;
  end

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  logic [3:0] addr_log[$];
  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit held = 1'b0;
  logic [3:0] held_data;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected words on every handshake, logs issued reads.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (rom_enable) begin
        en_cnt++;
        addr_log.push_back(rom_address);
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra: got %0h, expected no word", out_data);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL stream_word: got %0h, expected %0h", out_data, e);
          end
        end
      end
      if (out_valid && !out_ready) begin
        if (held) check("stall_stable", out_data, held_data);
        held = 1'b1;
        held_data = out_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_words(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[63-4*i -: 4]);
  endtask

  // Drives start in the current cycle (cycle 0) and returns in cycle 1.
  task automatic start_burst(input logic [3:0] a, input logic [3:0] l);
    addr_log.delete();
    en_cnt = 0;
    start = 1'b1;
    start_addr = a;
    len_m1 = l;
    tick();
    cyc = 1;
    start = 1'b0;
    check("c1_busy", busy, 1);
    check("c1_rom_enable", rom_enable, 1);
    check("c1_rom_address", rom_address, a);
    check("c1_out_valid", out_valid, 0);
  endtask

  // Advances until done is seen; optionally randomises out_ready each cycle.
  task automatic wait_done(input bit rnd);
    int budget;
    budget = 200;
    while (!done && budget > 0) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected done within 200 cycles");
    end else begin
      check("done_busy_low", busy, 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic run_full();
    push_words(64'hFEDCBA9876543A10, 16);
    start_burst(4'd0, 4'd15);
    tick();
    tick();
    check("full_first_valid_c3", out_valid, 1);
    check("full_first_word", out_data, 4'hF);
    wait_done(1'b0);
    check("full_done_cycle", cyc, 19);
    check("full_checksum", checksum, 4'h8);
    tick();
    check("full_checksum_hold", checksum, 4'h8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    rst = 1'b1;
    start = 1'b0;
    start_addr = 4'd0;
    len_m1 = 4'd0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_outputs", {rom_enable, rom_address, out_data, out_valid, busy, done, checksum}, 0);
    tick();

    // Full sweep
    run_full();

    // Wrap-around addresses
    push_words(64'h10FE << 48, 4);
    start_burst(4'd14, 4'd3);
    wait_done(1'b0);
    check("wrap_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", addr_log[0], 14);
      check("wrap_addr1", addr_log[1], 15);
      check("wrap_addr2", addr_log[2], 0);
      check("wrap_addr3", addr_log[3], 1);
    end
    check("wrap_checksum", checksum, 4'h0);
    tick();

    // Backpressure from cycle 0, release in cycle 10
    out_ready = 1'b0;
    push_words(64'hFEDCBA98 << 32, 8);
    start_burst(4'd0, 4'd7);
    repeat (8) tick();
    check("bp_enable_pulses", en_cnt, 2);
    check("bp_valid_held", out_valid, 1);
    check("bp_data_held", out_data, 4'hF);
    tick();
    out_ready = 1'b1;
    wait_done(1'b0);
    check("bp_total_reads", en_cnt, 8);
    check("bp_checksum", checksum, 4'h0);
    tick();

    // Random ready toggling
    push_words(64'hFEDCBA98 << 32, 8);
    start_burst(4'd0, 4'd7);
    wait_done(1'b1);
    check("rnd_total_reads", en_cnt, 8);
    check("rnd_checksum", checksum, 4'h0);
    tick();

    // Single word
    push_words(64'hA << 60, 1);
    start_burst(4'd13, 4'd0);
    wait_done(1'b0);
    check("single_done_cycle", cyc, 4);
    check("single_reads", en_cnt, 1);
    check("single_checksum", checksum, 4'hA);
    tick();

    // start during RUN is ignored
    push_words(64'hFEDC << 48, 4);
    start_burst(4'd0, 4'd3);
    start = 1'b1;
    start_addr = 4'd5;
    len_m1 = 4'd15;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    check("run_start_reads", en_cnt, 4);
    check("run_start_done_cycle", cyc, 7);
    tick();

    // start in the done cycle begins a new burst with checksum cleared
    push_words(64'hBA << 56, 2);
    start_burst(4'd4, 4'd1);
    wait_done(1'b0);
    check("b2b_first_checksum", checksum, 4'h1);
    push_words(64'h543 << 52, 3);
    start_burst(4'd10, 4'd2);
    check("b2b_checksum_cleared", checksum, 4'h0);
    wait_done(1'b0);
    check("b2b_second_checksum", checksum, 4'h2);
    tick();

    // Reset mid-burst
    push_words(64'hFEDCBA9876543A10, 16);
    start_burst(4'd0, 4'd15);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_outputs", {rom_enable, rom_address, out_data, out_valid, busy, done, checksum}, 0);
    rst = 1'b0;
    exp_q.delete();
    snap = done_cnt;
    repeat (4) tick();
    check("midrst_no_done", done_cnt, snap);
    run_full();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
